// File: rtl/mem_stage.sv
// MEM pipeline stage: 1024x32 data RAM with fault detection, branch/jump redirect,
// MEM/WB register, sticky access-fault capture and a saturating committed-store counter.
module mem_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:2] mem_PC_br,
  input  logic        mem_Zero,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_busB,
  input  logic [4:0]  mem_Rw,
  input  logic        mem_RegWr,
  input  logic        mem_Branch,
  input  logic        mem_Jump,
  input  logic        mem_MemWr,
  input  logic        mem_MemtoReg,
  output logic        PC_redirect,
  output logic [31:2] PC_target,
  output logic        flush,
  output logic [31:0] wb_dout,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_Rw,
  output logic        wb_RegWr,
  output logic        wb_MemtoReg,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [15:0] store_cnt
);

  // No handshake: one instruction is accepted every cycle, there is no stall or back-pressure.
  logic [31:0] ram_q [1024];

  logic [9:0]  ram_idx;
  logic        acc_valid;
  logic        acc_req;
  logic        store_commit;
  logic [31:0] rd_data;

  logic [31:0] wb_dout_d, wb_alu_result_d;
  logic [4:0]  wb_rw_d;
  logic        wb_regwr_d, wb_memtoreg_d;
  logic        fault_d;
  logic [31:0] fault_addr_d;
  logic [15:0] store_cnt_d;

  logic [31:0] wb_dout_q, wb_alu_result_q;
  logic [4:0]  wb_rw_q;
  logic        wb_regwr_q, wb_memtoreg_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic [15:0] store_cnt_q;

  always_comb begin
    ram_idx      = mem_alu_result[11:2];
    acc_valid    = (mem_alu_result[31:12] == 20'd0) && (mem_alu_result[1:0] == 2'b00);
    acc_req      = mem_MemWr | mem_MemtoReg;
    store_commit = mem_MemWr & acc_valid;
    // Combinational read sees the pre-edge word, so read-during-write returns old data.
    rd_data      = acc_valid ? ram_q[ram_idx] : 32'd0;
  end

  always_comb begin
    PC_redirect = mem_Jump | (mem_Branch & mem_Zero);
    PC_target   = mem_PC_br;
    flush       = PC_redirect;
  end

  always_comb begin
    wb_dout_d       = rd_data;
    wb_alu_result_d = mem_alu_result;
    wb_rw_d         = mem_Rw;
    wb_regwr_d      = mem_RegWr;
    wb_memtoreg_d   = mem_MemtoReg;
    fault_d         = fault_q | (acc_req & ~acc_valid);
    fault_addr_d    = fault_addr_q;
    if (!fault_q && fault_d) fault_addr_d = mem_alu_result;
    store_cnt_d     = store_cnt_q;
    if (store_commit && store_cnt_q != 16'hFFFF) store_cnt_d = store_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_dout_q       <= 32'd0;
      wb_alu_result_q <= 32'd0;
      wb_rw_q         <= 5'd0;
      wb_regwr_q      <= 1'b0;
      wb_memtoreg_q   <= 1'b0;
      fault_q         <= 1'b0;
      fault_addr_q    <= 32'd0;
      store_cnt_q     <= 16'd0;
    end else begin
      wb_dout_q       <= wb_dout_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_rw_q         <= wb_rw_d;
      wb_regwr_q      <= wb_regwr_d;
      wb_memtoreg_q   <= wb_memtoreg_d;
      fault_q         <= fault_d;
      fault_addr_q    <= fault_addr_d;
      store_cnt_q     <= store_cnt_d;
    end
  end

  // RAM contents survive reset; Reset only blocks the write strobe.
  always_ff @(posedge Clk) begin
    if (store_commit && !Reset) ram_q[ram_idx] <= mem_busB;
  end

  assign wb_dout       = wb_dout_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_Rw         = wb_rw_q;
  assign wb_RegWr      = wb_regwr_q;
  assign wb_MemtoReg   = wb_memtoreg_q;
  assign fault         = fault_q;
  assign fault_addr    = fault_addr_q;
  assign store_cnt     = store_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: memory op table, redirect table,
// plus hand-written reset and store-counter saturation sequences.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:2] mem_PC_br = '0;
  logic        mem_Zero = 1'b0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_busB = '0;
  logic [4:0]  mem_Rw = '0;
  logic        mem_RegWr = 1'b0;
  logic        mem_Branch = 1'b0;
  logic        mem_Jump = 1'b0;
  logic        mem_MemWr = 1'b0;
  logic        mem_MemtoReg = 1'b0;
  logic        PC_redirect;
  logic [31:2] PC_target;
  logic        flush;
  logic [31:0] wb_dout;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_Rw;
  logic        wb_RegWr;
  logic        wb_MemtoReg;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] store_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  mem_stage dut (
    .Clk(Clk), .Reset(Reset), .mem_PC_br(mem_PC_br), .mem_Zero(mem_Zero),
    .mem_alu_result(mem_alu_result), .mem_busB(mem_busB), .mem_Rw(mem_Rw),
    .mem_RegWr(mem_RegWr), .mem_Branch(mem_Branch), .mem_Jump(mem_Jump),
    .mem_MemWr(mem_MemWr), .mem_MemtoReg(mem_MemtoReg),
    .PC_redirect(PC_redirect), .PC_target(PC_target), .flush(flush),
    .wb_dout(wb_dout), .wb_alu_result(wb_alu_result), .wb_Rw(wb_Rw),
    .wb_RegWr(wb_RegWr), .wb_MemtoReg(wb_MemtoReg), .fault(fault),
    .fault_addr(fault_addr), .store_cnt(store_cnt)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  typedef struct {
    logic        memwr;
    logic        memtoreg;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic [15:0] exp_cnt;
    logic        exp_fault;
    logic [31:0] exp_faddr;
  } mem_vec_t;

  typedef struct {
    logic        branch;
    logic        jump;
    logic        zero;
    logic [31:2] pc_br;
    logic        exp_redirect;
  } br_vec_t;

  mem_vec_t mem_tbl[15];
  br_vec_t  br_tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_mem(input logic memwr, input logic memtoreg, input logic regwr,
                           input logic [4:0] rw, input logic [31:0] addr, input logic [31:0] data);
    mem_MemWr      = memwr;
    mem_MemtoReg   = memtoreg;
    mem_RegWr      = regwr;
    mem_Rw         = rw;
    mem_alu_result = addr;
    mem_busB       = data;
  endtask

  task automatic drive_idle();
    drive_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    //             wr memtoreg regwr rw  addr          data          chk dout          cnt fault faddr
    mem_tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0,         16'd1, 1'b0, 32'h0};
    mem_tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'd2, 1'b0, 32'h0};
    mem_tbl[2]  = '{1'b0, 1'b1, 1'b1, 5'd5,  32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'd2, 1'b0, 32'h0};
    mem_tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0020, 32'h0000_0005, 1'b0, 32'h0,         16'd3, 1'b0, 32'h0};
    mem_tbl[4]  = '{1'b1, 1'b1, 1'b1, 5'd7,  32'h0000_0020, 32'h0000_0001, 1'b1, 32'h0000_0005, 16'd4, 1'b0, 32'h0};
    mem_tbl[5]  = '{1'b0, 1'b1, 1'b1, 5'd8,  32'h0000_0020, 32'h0,         1'b1, 32'h0000_0001, 16'd4, 1'b0, 32'h0};
    mem_tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0,         16'd5, 1'b0, 32'h0};
    mem_tbl[7]  = '{1'b0, 1'b1, 1'b1, 5'd31, 32'h0000_0FFC, 32'h0,         1'b1, 32'hCAFE_F00D, 16'd5, 1'b0, 32'h0};
    mem_tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'd9,  32'h1234_5678, 32'h0,         1'b1, 32'h0,         16'd5, 1'b0, 32'h0};
    mem_tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_1002, 32'hBAD0_BAD0, 1'b1, 32'h0,         16'd5, 1'b1, 32'h0000_1002};
    mem_tbl[10] = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0003, 32'h0,         1'b1, 32'h0,         16'd5, 1'b1, 32'h0000_1002};
    mem_tbl[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_0012, 32'h0000_0BAD, 1'b1, 32'h0,         16'd5, 1'b1, 32'h0000_1002};
    mem_tbl[12] = '{1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_0000, 32'h0,         1'b1, 32'h1234_5678, 16'd5, 1'b1, 32'h0000_1002};
    mem_tbl[13] = '{1'b0, 1'b1, 1'b1, 5'd2,  32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'd5, 1'b1, 32'h0000_1002};
    mem_tbl[14] = '{1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_1000, 32'h0,         1'b1, 32'h0,         16'd5, 1'b1, 32'h0000_1002};

    //            branch jump  zero  pc_br        redirect
    br_tbl[0] = '{1'b1, 1'b0, 1'b1, 30'h0000_0100, 1'b1};
    br_tbl[1] = '{1'b1, 1'b0, 1'b0, 30'h0000_0100, 1'b0};
    br_tbl[2] = '{1'b0, 1'b1, 1'b0, 30'h0000_0200, 1'b1};
    br_tbl[3] = '{1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b0};
    br_tbl[4] = '{1'b1, 1'b1, 1'b1, 30'h2AAA_AAAA, 1'b1};
    br_tbl[5] = '{1'b0, 1'b0, 1'b0, 30'h0000_0004, 1'b0};

    // Reset: assert between edges, outputs must clear without a clock edge.
    #2 Reset = 1'b1;
    #1;
    check("rst_wb_dout", wb_dout, 32'd0);
    check("rst_wb_alu", wb_alu_result, 32'd0);
    check("rst_wb_rw", {27'd0, wb_Rw}, 32'd0);
    check("rst_wb_regwr", {31'd0, wb_RegWr}, 32'd0);
    check("rst_wb_memtoreg", {31'd0, wb_MemtoReg}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_store_cnt", {16'd0, store_cnt}, 32'd0);
    step();
    step();
    Reset = 1'b0;

    // Redirect table, combinational: checked in the same cycle.
    for (int i = 0; i < 6; i++) begin
      mem_Branch = br_tbl[i].branch;
      mem_Jump   = br_tbl[i].jump;
      mem_Zero   = br_tbl[i].zero;
      mem_PC_br  = br_tbl[i].pc_br;
      #1;
      check($sformatf("br%0d_redirect", i), {31'd0, PC_redirect}, {31'd0, br_tbl[i].exp_redirect});
      check($sformatf("br%0d_flush", i), {31'd0, flush}, {31'd0, br_tbl[i].exp_redirect});
      check($sformatf("br%0d_target", i), {2'b00, PC_target}, {2'b00, br_tbl[i].pc_br});
    end
    mem_Branch = 1'b0;
    mem_Jump   = 1'b0;
    mem_Zero   = 1'b0;

    // Memory op table: each op applied for one cycle, WB checked one edge later.
    step();
    for (int i = 0; i < 15; i++) begin
      drive_mem(mem_tbl[i].memwr, mem_tbl[i].memtoreg, mem_tbl[i].regwr,
                mem_tbl[i].rw, mem_tbl[i].addr, mem_tbl[i].data);
      step();
      if (mem_tbl[i].chk_dout)
        check($sformatf("op%0d_dout", i), wb_dout, mem_tbl[i].exp_dout);
      check($sformatf("op%0d_alu", i), wb_alu_result, mem_tbl[i].addr);
      check($sformatf("op%0d_rw", i), {27'd0, wb_Rw}, {27'd0, mem_tbl[i].rw});
      check($sformatf("op%0d_regwr", i), {31'd0, wb_RegWr}, {31'd0, mem_tbl[i].regwr});
      check($sformatf("op%0d_memtoreg", i), {31'd0, wb_MemtoReg}, {31'd0, mem_tbl[i].memtoreg});
      check($sformatf("op%0d_cnt", i), {16'd0, store_cnt}, {16'd0, mem_tbl[i].exp_cnt});
      check($sformatf("op%0d_fault", i), {31'd0, fault}, {31'd0, mem_tbl[i].exp_fault});
      check($sformatf("op%0d_faddr", i), fault_addr, mem_tbl[i].exp_faddr);
    end

    // Mid-operation reset drops in-flight WB contents immediately.
    drive_mem(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0010, 32'h0);
    step();
    check("pre_rst_regwr", {31'd0, wb_RegWr}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("midrst_regwr", {31'd0, wb_RegWr}, 32'd0);
    check("midrst_dout", wb_dout, 32'd0);
    check("midrst_fault", {31'd0, fault}, 32'd0);
    check("midrst_faddr", fault_addr, 32'd0);
    check("midrst_cnt", {16'd0, store_cnt}, 32'd0);
    // Redirect logic keeps following its inputs while Reset is high.
    mem_Jump  = 1'b1;
    mem_PC_br = 30'h0000_0123;
    #1;
    check("rst_redirect", {31'd0, PC_redirect}, 32'd1);
    check("rst_target", {2'b00, PC_target}, 32'h0000_0123);
    mem_Jump = 1'b0;
    // A store held across an edge while in reset must not land in RAM.
    drive_mem(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0010, 32'h1111_1111);
    step();
    check("rst_hold_cnt", {16'd0, store_cnt}, 32'd0);
    drive_idle();
    #2 Reset = 1'b0;
    drive_mem(1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0010, 32'h0);
    step();
    check("post_rst_dout", wb_dout, 32'hDEAD_BEEF);
    check("post_rst_cnt", {16'd0, store_cnt}, 32'd0);

    // Store counter saturation.
    drive_mem(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0040, 32'h0000_0077);
    repeat (65534) @(posedge Clk);
    #1;
    check("cnt_65534", {16'd0, store_cnt}, 32'h0000_FFFE);
    step();
    check("cnt_65535", {16'd0, store_cnt}, 32'h0000_FFFF);
    step();
    step();
    check("cnt_sat", {16'd0, store_cnt}, 32'h0000_FFFF);
    check("sat_fault", {31'd0, fault}, 32'd0);
    drive_idle();

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
